// File: rtl/matrix_regbank_if.sv
// Host-side channels of matrix_regbank: command, write-beat and read-beat handshakes.
interface matrix_regbank_if #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
);
  localparam int AW = $clog2(DIM*DIM);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [AW-1:0]     cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [ELEM_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ELEM_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/matrix_regbank.sv
// Operand A/B and result C register bank with burst command access.
// Define REGBANK_SNAPSHOT_EN to read each C burst from a copy taken at command acceptance.
module matrix_regbank #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  matrix_regbank_if.slave           bus,
  input  logic [DIM*DIM*ELEM_W-1:0] matrix_C,
  output logic [DIM*DIM*ELEM_W-1:0] matrix_A,
  output logic [DIM*DIM*ELEM_W-1:0] matrix_B,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int N  = DIM*DIM;
  localparam int AW = $clog2(N);
  localparam logic [AW:0] LAST = (AW+1)'(N-1);
  localparam logic [1:0] OP_RD_C = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, cnt_q;
  logic              target_a_q;
  logic [ELEM_W-1:0] a_q [N];
  logic [ELEM_W-1:0] b_q [N];
  logic [ELEM_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ELEM_W-1:0] c_live [N];
  logic [ELEM_W-1:0] c_src  [N];
  logic              cmd_fire, range_bad, cmd_accept, wr_fire, rd_fire, last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign c_live[gi]                       = matrix_C[gi*ELEM_W +: ELEM_W];
      assign matrix_A[gi*ELEM_W +: ELEM_W]    = a_q[gi];
      assign matrix_B[gi*ELEM_W +: ELEM_W]    = b_q[gi];
    end
  endgenerate

`ifdef REGBANK_SNAPSHOT_EN
  logic [ELEM_W-1:0] shadow_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else if (cmd_accept && bus.cmd_op == OP_RD_C) begin
      for (int i = 0; i < N; i++) shadow_q[i] <= c_live[i];
    end
  end

  assign c_src = shadow_q;
`else
  assign c_src = c_live;
`endif

  // Range check is done one bit wider so addr+len cannot wrap into range.
  assign cmd_fire   = bus.cmd_valid && (state_q == IDLE);
  assign range_bad  = ({1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len}) > LAST;
  assign cmd_accept = cmd_fire && !range_bad;
  assign wr_fire    = (state_q == WRITE) && bus.wr_valid;
  assign rd_fire    = (state_q == READ) && rd_valid_q && bus.rd_ready;
  assign last_beat  = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    bus.cmd_ready = (state_q == IDLE);
    bus.wr_ready  = (state_q == WRITE);
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (range_bad)                  err_d   = 1'b1;
          else if (bus.cmd_op == OP_RD_C) state_d = READ;
          else if (bus.cmd_op == OP_CLR)  state_d = CLEAR;
          else                            state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr_fire && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        if (rd_fire && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The first read beat is loaded at acceptance so rd_valid rises one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      target_a_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (cmd_accept) begin
        ptr_q      <= bus.cmd_addr;
        cnt_q      <= bus.cmd_len;
        target_a_q <= bus.cmd_op[0];
        if (bus.cmd_op == OP_RD_C) begin
          rd_data_q  <= c_live[bus.cmd_addr];
          rd_valid_q <= 1'b1;
          ptr_q      <= bus.cmd_addr + AW'(1);
        end
      end
      if (wr_fire) begin
        ptr_q <= ptr_q + AW'(1);
        cnt_q <= cnt_q - AW'(1);
      end
      if (rd_fire) begin
        if (last_beat) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q <= c_src[ptr_q];
          ptr_q     <= ptr_q + AW'(1);
          cnt_q     <= cnt_q - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (wr_fire) begin
      if (target_a_q) a_q[ptr_q] <= bus.wr_data;
      else            b_q[ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: tb/tb_matrix_regbank.sv
// Self-checking bench for matrix_regbank: directed corner cases, a command table and random bursts.
module tb_matrix_regbank;
  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N      = DIM*DIM;
  localparam int AW     = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N*ELEM_W-1:0] matrix_C, matrix_A, matrix_B;
  logic                busy, done, err;

  matrix_regbank_if #(.ELEM_W(ELEM_W), .DIM(DIM)) bus ();

  matrix_regbank #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .matrix_C (matrix_C),
    .matrix_A (matrix_A),
    .matrix_B (matrix_B),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ref_a [N];
  logic [7:0]  ref_b [N];
  logic [7:0]  ref_c [N];
  logic [7:0]  wdata [N];

  typedef struct {
    logic [1:0] op;
    int         addr;
    int         len;
    bit         exp_err;
  } vec_t;

  vec_t vecs [10];

  always_comb begin
    matrix_C = '0;
    for (int i = 0; i < N; i++) matrix_C[i*ELEM_W +: ELEM_W] = ref_c[i];
  end

  task automatic check(input string name, input logic [N*ELEM_W-1:0] act, input logic [N*ELEM_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mats(input string tag);
    logic [N*ELEM_W-1:0] ea, eb;
    for (int i = 0; i < N; i++) begin
      ea[i*ELEM_W +: ELEM_W] = ref_a[i];
      eb[i*ELEM_W +: ELEM_W] = ref_b[i];
    end
    check({tag, "_A"}, matrix_A, ea);
    check({tag, "_B"}, matrix_B, eb);
  endtask

  // Called at a falling edge; returns at the falling edge where the command's done/err is visible.
  task automatic run_cmd(input logic [1:0] op, input int addr, input int len, input bit exp_err,
                         input logic [31:0] pat, input bit use_pat, input int mut_at);
    int         k;
    int         cyc;
    bit         rdy;
    logic [7:0] snap [N];
    logic [7:0] exp_d;
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'($urandom);
    snap = ref_c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    check("done_single", done, 1'b0);
    if (exp_err) begin
      check("err_pulse", err, 1'b1);
      check("busy_reject", busy, 1'b0);
      check_mats("reject");
      @(negedge clk);
      check("err_single", err, 1'b0);
      check("done_reject", done, 1'b0);
      $display("[TB] op=%0d addr=%0d len=%0d rejected", op, addr, len);
      return;
    end
    check("err_low", err, 1'b0);
    check("busy_cmd", busy, 1'b1);
    check("cmd_ready_busy", bus.cmd_ready, 1'b0);
    case (op)
      2'd0, 2'd1: begin
        for (int b = 0; b <= len; b++) begin
          while ($urandom_range(0, 3) == 0) begin
            bus.wr_valid = 1'b0;
            @(negedge clk);
          end
          check("wr_ready", bus.wr_ready, 1'b1);
          bus.wr_valid = 1'b1;
          bus.wr_data  = wdata[b];
          @(negedge clk);
          if (op == 2'd1) ref_a[addr+b] = wdata[b];
          else            ref_b[addr+b] = wdata[b];
          check("wr_done", done, b == len);
          check_mats("write");
        end
        bus.wr_valid = 1'b0;
      end
      2'd2: begin
        k     = 0;
        cyc   = 0;
        exp_d = ref_c[addr];
        while (k <= len && cyc < 300) begin
          check("rd_valid", bus.rd_valid, 1'b1);
          check("rd_data", bus.rd_data, exp_d);
          check("rd_done_low", done, 1'b0);
          if (k == mut_at)
            for (int i = 0; i < N; i++) ref_c[i] = ref_c[i] + 8'd1 + 8'($urandom_range(0, 200));
          rdy = (use_pat && cyc < 32) ? pat[cyc] : ($urandom_range(0, 2) != 0);
          bus.rd_ready = rdy;
          @(negedge clk);
          cyc++;
          if (rdy) begin
            k++;
            if (k <= len) begin
`ifdef REGBANK_SNAPSHOT_EN
              exp_d = snap[addr+k];
`else
              exp_d = ref_c[addr+k];
`endif
            end
          end
        end
        bus.rd_ready = 1'b0;
        if (cyc >= 300) begin
          tests++;
          fails++;
          $display("FAIL read_timeout: got %0d beats required %0d", k, len + 1);
        end
        check("rd_valid_end", bus.rd_valid, 1'b0);
        check("rd_done", done, 1'b1);
      end
      default: begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          ref_a[i] = '0;
          ref_b[i] = '0;
        end
        check("clear_done", done, 1'b1);
        check_mats("clear");
      end
    endcase
    check("busy_end", busy, 1'b0);
    $display("[TB] op=%0d addr=%0d len=%0d completed", op, addr, len);
  endtask

  initial begin
    int op, addr, len;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
      ref_c[i] = 8'($urandom);
    end

    vecs[0] = '{2'd0, 20, 5, 1'b1};
    vecs[1] = '{2'd0, 20, 4, 1'b0};
    vecs[2] = '{2'd1, 24, 0, 1'b0};
    vecs[3] = '{2'd2, 24, 0, 1'b0};
    vecs[4] = '{2'd2, 24, 1, 1'b1};
    vecs[5] = '{2'd1, 31, 0, 1'b1};
    vecs[6] = '{2'd2, 0, 31, 1'b1};
    vecs[7] = '{2'd0, 12, 12, 1'b0};
    vecs[8] = '{2'd2, 13, 12, 1'b1};
    vecs[9] = '{2'd2, 0, 24, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check_mats("reset");
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_rd_valid", bus.rd_valid, 1'b0);
    check("reset_rd_data", bus.rd_data, 8'h00);
    rst_n = 1'b1;
    check("release_cmd_ready", bus.cmd_ready, 1'b1);

    // Reset asserted asynchronously in the middle of a 4-beat write to A at 3
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_addr  = AW'(3);
    bus.cmd_len   = AW'(3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h11;
    @(negedge clk);
    ref_a[3] = 8'h11;
    bus.wr_data = 8'h22;
    @(negedge clk);
    ref_a[4] = 8'h22;
    check_mats("midwrite");
    #2 rst_n = 1'b0;
    #1 bus.wr_valid = 1'b0;
    for (int i = 0; i < N; i++) ref_a[i] = '0;
    check_mats("async_reset");
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_cmd_ready", bus.cmd_ready, 1'b1);
    check("async_reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_done", done, 1'b0);
    check("post_reset_busy", busy, 1'b0);
    $display("[TB] reset during write burst");

    // Full-range write of A with 1..25
    for (int i = 0; i < N; i++) wdata[i] = 8'(i + 1);
    run_cmd(2'd1, 0, 24, 1'b0, 32'h0, 1'b0, -1);

    // Out-of-range write of B, then the largest legal one at the same address
    for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
    run_cmd(2'd0, 20, 5, 1'b1, 32'h0, 1'b0, -1);
    run_cmd(2'd0, 20, 4, 1'b0, 32'h0, 1'b0, -1);

    // Read with rd_ready 1,0,1,1
    run_cmd(2'd2, 6, 2, 1'b0, 32'b1101, 1'b1, -1);

    // matrix_C changes after the first beat is presented
    run_cmd(2'd2, 10, 2, 1'b0, 32'b111, 1'b1, 0);

    // Clear with both matrices nonzero
    for (int i = 0; i < N; i++) wdata[i] = 8'($urandom_range(1, 255));
    run_cmd(2'd0, 0, 24, 1'b0, 32'h0, 1'b0, -1);
    run_cmd(2'd3, 0, 0, 1'b0, 32'h0, 1'b0, -1);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
      run_cmd(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].exp_err, 32'h0, 1'b0, -1);
    end

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 3);
      if (op == 3 && $urandom_range(0, 2) != 0) op = $urandom_range(0, 2);
      addr = $urandom_range(0, N - 1);
      len  = ($urandom_range(0, 4) != 0) ? $urandom_range(0, N - 1 - addr) : $urandom_range(0, 31);
      for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < N; i++) ref_c[i] = 8'($urandom);
      run_cmd(2'(op), addr, len, (addr + len) > (N - 1), 32'h0, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_regbank.md
# matrix_regbank

Parametrised operand/result register bank for the matrix coprocessor. Holds operand matrices A and B as flat element vectors feeding the compute array and returns elements of result matrix C to the host bus. Replaces single-element, edge-triggered access with clocked burst commands using valid/ready handshakes, auto-incrementing addresses, range checking and a clear operation.

## Interface
- ELEM_W, 8, bits per matrix element
- DIM, 5, matrix is DIM x DIM; N = DIM*DIM elements
- AW, $clog2(DIM*DIM), element address/length width (derived, do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  0 = write B, 1 = write A, 2 = read C, 3 = clear A and B
- cmd_addr  in  AW  first element index (row*DIM+col)
- cmd_len  in  AW  burst beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted when both high
- wr_data  in  ELEM_W  write element
- rd_valid  out  1  read beat available
- rd_ready  in  1  read beat consumed when both high
- rd_data  out  ELEM_W  read element
- matrix_C  in  N*ELEM_W  result matrix from compute array
- matrix_A, matrix_B  out  N*ELEM_W  operand matrices; element i at [i*ELEM_W +: ELEM_W]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- States: IDLE, WRITE, READ, CLEAR. cmd_ready = 1 only in IDLE.
- Acceptance check: if cmd_addr + cmd_len > N-1 (computed at AW+1 bits, no wrap), command rejected: err pulses next cycle, state stays IDLE, no storage change, no done.
- Write (op 0/1): IDLE -> WRITE; ptr = cmd_addr, cnt = cmd_len. wr_ready = 1 in WRITE. Each accepted beat writes wr_data into element ptr of the target matrix, ptr+1, cnt-1. Beat with cnt = 0 -> IDLE, done pulse.
- Read (op 2): IDLE -> READ; rd_data/rd_valid registered. Beat for ptr presented; held stable while rd_valid && !rd_ready. On handshake, next element presented the following cycle (no bubble); after last beat rd_valid drops, -> IDLE, done pulse.
- Clear (op 3): IDLE -> CLEAR for one cycle; all elements of A and B zeroed; -> IDLE, done pulse.
- wr_valid outside WRITE ignored; rd_ready outside READ ignored.

## Timing
- Reset (async assert, any state, mid-burst included): state IDLE, matrix_A = matrix_B = 0, rd_data = 0, rd_valid = 0, busy = 0, done = 0, err = 0, cmd_ready = 1 after reset release, ptr = cnt = 0. Partially written bursts are discarded by the zeroing.
- Write beat visible on matrix_A/B the cycle after handshake.
- Read latency: first rd_valid one cycle after command acceptance; sustained 1 beat/cycle with rd_ready held high.
- done / err: single-cycle pulses, the cycle after last beat / rejection / CLEAR.
- cmd_ready low from acceptance cycle+1 until the cycle done is high; next command may be accepted in the done cycle.
- Single-beat burst (cmd_len = 0) and full-range burst (addr 0, len N-1) legal.

## Configuration
- REGBANK_SNAPSHOT_EN defined: on read-command acceptance, matrix_C copied into an internal N*ELEM_W shadow register; all beats of that burst read from the shadow, so the burst is coherent even if matrix_C changes mid-burst.
- Not defined: no shadow; each beat samples live matrix_C at the cycle it is loaded into rd_data.

## Test plan
- Reset mid-WRITE after 2 of 4 beats (A, addr 3) -> matrix_A all zero, busy 0, cmd_ready 1, no done.
- Write A addr 0 len 24 with values 1..25 (DIM 5) -> matrix_A element i = i+1, done one cycle after beat 25, matrix_B unchanged.
- Write B addr 20 len 5 -> err pulse next cycle, matrix_B unchanged, state IDLE; then addr 20 len 4 accepted.
- Read C addr 6 len 2 with rd_ready toggling 1,0,1,1 -> rd_data = C[6], C[7] (held through stall), C[8], then done.
- With REGBANK_SNAPSHOT_EN: change matrix_C after first beat of a 3-beat read -> all beats return pre-change values; without macro, later beats return new values.
- Write A and B with nonzero data, issue clear -> both zero the cycle after CLEAR, done pulses once, busy 1 for exactly one cycle.
